// File: rtl/sprite_anim_renderer.sv
// Animated, scaled sprite compositor over a background colour, fed by an external sprite ROM.
// Optional macro SPRITE_HFLIP_EN adds a frame-latched horizontal mirror input (hflip).
module sprite_anim_renderer #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int SCALE_SHIFT = 1,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 8,
    parameter int IDX_W       = 3,
    parameter int ROM_LAT     = 1,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(NUM_FRAMES*SPR_W*SPR_H),
    localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               frame_start,
    input  logic [9:0]         spr_x,
    input  logic [9:0]         spr_y,
    input  logic               anim_en,
`ifdef SPRITE_HFLIP_EN
    input  logic               hflip,
`endif
    input  logic [3:0]         bg_red,
    input  logic [3:0]         bg_green,
    input  logic [3:0]         bg_blue,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pal_index,
    input  logic [3:0]         pal_red,
    input  logic [3:0]         pal_green,
    input  logic [3:0]         pal_blue,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic [FRAME_W-1:0] frame_idx
);
    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int COL_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [10:0] SIZE_X = 11'(SPR_W << SCALE_SHIFT);
    localparam logic [10:0] SIZE_Y = 11'(SPR_H << SCALE_SHIFT);
    localparam int DLY_W  = 14;

    logic [TICK_W-1:0]  tick_reg, tick_next;
    logic [FRAME_W-1:0] frame_reg, frame_next;
    logic [9:0]         lx_reg, ly_reg;
`ifdef SPRITE_HFLIP_EN
    logic               hflip_reg;
`endif

    always_comb begin
        tick_next  = tick_reg;
        frame_next = frame_reg;
        if (frame_start && anim_en) begin
            if (tick_reg == TICK_W'(FRAME_TICKS-1)) begin
                tick_next  = '0;
                frame_next = (frame_reg == FRAME_W'(NUM_FRAMES-1)) ? '0 : frame_reg + 1'b1;
            end else begin
                tick_next = tick_reg + 1'b1;
            end
        end
    end

    // Position (and mirror) only change at frame_start so a frame never tears.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            tick_reg  <= '0;
            frame_reg <= '0;
            lx_reg    <= '0;
            ly_reg    <= '0;
`ifdef SPRITE_HFLIP_EN
            hflip_reg <= 1'b0;
`endif
        end else begin
            tick_reg  <= tick_next;
            frame_reg <= frame_next;
            if (frame_start) begin
                lx_reg    <= spr_x;
                ly_reg    <= spr_y;
`ifdef SPRITE_HFLIP_EN
                hflip_reg <= hflip;
`endif
            end
        end
    end

    assign frame_idx = frame_reg;

    logic [10:0]       dx, dy;
    logic              hit;
    logic [COL_W-1:0]  col_raw, col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;

    // 11-bit differences; the >= terms stop negative offsets wrapping into range.
    assign dx  = {1'b0, DrawX} - {1'b0, lx_reg};
    assign dy  = {1'b0, DrawY} - {1'b0, ly_reg};
    assign hit = (DrawX >= lx_reg) && (dx < SIZE_X) && (DrawY >= ly_reg) && (dy < SIZE_Y);

    assign col_raw = COL_W'(dx >> SCALE_SHIFT);
    assign row     = ROW_W'(dy >> SCALE_SHIFT);
`ifdef SPRITE_HFLIP_EN
    assign col = hflip_reg ? (COL_W'(SPR_W-1) - col_raw) : col_raw;
`else
    assign col = col_raw;
`endif

    assign addr = ADDR_W'(frame_reg) * ADDR_W'(SPR_W*SPR_H)
                + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
    assign rom_address = hit ? addr : '0;

    // Side-band pixel info travels alongside the ROM read so it lands with rom_q.
    logic [DLY_W-1:0] dly_reg [ROM_LAT];
    logic [DLY_W-1:0] stage_in;
    assign stage_in = {hit, blank, bg_red, bg_green, bg_blue};

    generate
        for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_dly
            if (gi == 0) begin : g_first
                always_ff @(posedge vga_clk) begin
                    if (reset) dly_reg[gi] <= '0;
                    else       dly_reg[gi] <= stage_in;
                end
            end else begin : g_rest
                always_ff @(posedge vga_clk) begin
                    if (reset) dly_reg[gi] <= '0;
                    else       dly_reg[gi] <= dly_reg[gi-1];
                end
            end
        end
    endgenerate

    logic       hit_d, blank_d;
    logic [3:0] bg_r_d, bg_g_d, bg_b_d;
    assign {hit_d, blank_d, bg_r_d, bg_g_d, bg_b_d} = dly_reg[ROM_LAT-1];

    assign pal_index = rom_q;

    logic [3:0] red_reg, green_reg, blue_reg;
    logic [3:0] red_next, green_next, blue_next;

    always_comb begin
        red_next   = 4'h0;
        green_next = 4'h0;
        blue_next  = 4'h0;
        if (blank_d) begin
            if (hit_d && (rom_q != IDX_W'(TRANSP_IDX))) begin
                red_next   = pal_red;
                green_next = pal_green;
                blue_next  = pal_blue;
            end else begin
                red_next   = bg_r_d;
                green_next = bg_g_d;
                blue_next  = bg_b_d;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            red_reg   <= 4'h0;
            green_reg <= 4'h0;
            blue_reg  <= 4'h0;
        end else begin
            red_reg   <= red_next;
            green_reg <= green_next;
            blue_reg  <= blue_next;
        end
    end

    assign red   = red_reg;
    assign green = green_reg;
    assign blue  = blue_reg;
endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer (default parameters, ROM_LAT = 1).
// Palette model: red = idx+8, green = {idx,1}, blue = 15-idx.
module tb_sprite_anim_renderer;
    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY, spr_x, spr_y;
    logic        blank, frame_start, anim_en;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic [11:0] rom_address;
    logic [2:0]  rom_q, pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [3:0]  red, green, blue;
    logic [1:0]  frame_idx;
`ifdef SPRITE_HFLIP_EN
    logic        hflip;
`endif

    int checks = 0;
    int errors = 0;

    always #5 vga_clk = ~vga_clk;

    assign pal_red   = 4'(pal_index) + 4'd8;
    assign pal_green = {pal_index, 1'b1};
    assign pal_blue  = 4'hF - 4'(pal_index);

    sprite_anim_renderer dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .spr_x(spr_x), .spr_y(spr_y),
        .anim_en(anim_en),
`ifdef SPRITE_HFLIP_EN
        .hflip(hflip),
`endif
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue), .frame_idx(frame_idx)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        bl;
        logic [3:0]  bg;
        logic [2:0]  rq;
        logic [11:0] exp_addr;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs [10];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic pulse(input logic [9:0] sx, input logic [9:0] sy, input logic en);
        spr_x = sx;
        spr_y = sy;
        anim_en = en;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic bl,
                         input logic [3:0] bg, input logic [2:0] rq);
        DrawX = x;
        DrawY = y;
        blank = bl;
        bg_red = bg;
        bg_green = bg;
        bg_blue = bg;
        rom_q = rq;
    endtask

    // Inputs held steady: address checked combinationally, colour after ROM_LAT+1 edges.
    task automatic apply_check(input string name, input logic [9:0] x, input logic [9:0] y,
                               input logic bl, input logic [3:0] bg, input logic [2:0] rq,
                               input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
        drive(x, y, bl, bg, rq);
        #1;
        chk({name, " addr"}, 32'(rom_address), 32'(exp_addr));
        step(2);
        chk({name, " rgb"}, 32'({red, green, blue}), 32'(exp_rgb));
    endtask

    initial begin
        // sprite latched at (100,50), frame 0
        vecs[0] = '{10'd100, 10'd50, 1'b1, 4'h3, 3'd5, 12'd0,   12'hDBA};
        vecs[1] = '{10'd163, 10'd50, 1'b1, 4'h3, 3'd5, 12'd31,  12'hDBA};
        vecs[2] = '{10'd164, 10'd50, 1'b1, 4'h3, 3'd5, 12'd0,   12'h333};
        vecs[3] = '{10'd100, 10'd50, 1'b1, 4'h3, 3'd0, 12'd0,   12'h333};
        vecs[4] = '{10'd100, 10'd50, 1'b0, 4'h3, 3'd5, 12'd0,   12'h000};
        vecs[5] = '{10'd99,  10'd50, 1'b1, 4'h3, 3'd5, 12'd0,   12'h333};
        vecs[6] = '{10'd110, 10'd60, 1'b1, 4'h3, 3'd7, 12'd165, 12'hFF8};
        vecs[7] = '{10'd101, 10'd113, 1'b1, 4'h6, 3'd2, 12'd992, 12'hA5D};
        vecs[8] = '{10'd101, 10'd114, 1'b1, 4'h6, 3'd2, 12'd0,   12'h666};
        vecs[9] = '{10'd101, 10'd49, 1'b1, 4'h6, 3'd2, 12'd0,   12'h666};

        reset = 1'b1;
        frame_start = 1'b0;
        anim_en = 1'b0;
        spr_x = '0;
        spr_y = '0;
`ifdef SPRITE_HFLIP_EN
        hflip = 1'b0;
`endif
        drive(10'd0, 10'd0, 1'b1, 4'hF, 3'd5);

        // reset: three cycles, a frame_start in the middle must be ignored
        step(1);
        spr_x = 10'd300;
        spr_y = 10'd300;
        anim_en = 1'b1;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        anim_en = 1'b0;
        step(1);
        chk("reset rgb", 32'({red, green, blue}), 32'h000);
        chk("reset frame_idx", 32'(frame_idx), 32'd0);
        chk("reset rom_address", 32'(rom_address), 32'd0);

        reset = 1'b0;
        step(1);
        chk("post-reset edge1 rgb", 32'({red, green, blue}), 32'h000);
        step(1);
        chk("post-reset edge2 rgb", 32'({red, green, blue}), 32'hDBA);
        chk("post-reset frame_idx", 32'(frame_idx), 32'd0);

        pulse(10'd100, 10'd50, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].bl,
                        vecs[i].bg, vecs[i].rq, vecs[i].exp_addr, vecs[i].exp_rgb);
        end

        // exact latency: miss -> hit transition shows up after exactly two edges
        drive(10'd164, 10'd50, 1'b1, 4'h3, 3'd5);
        step(3);
        drive(10'd100, 10'd50, 1'b1, 4'h3, 3'd5);
        step(1);
        chk("latency edge1 rgb", 32'({red, green, blue}), 32'h333);
        step(1);
        chk("latency edge2 rgb", 32'({red, green, blue}), 32'hDBA);

        // animation
        repeat (7) pulse(10'd100, 10'd50, 1'b1);
        chk("anim 7 pulses frame", 32'(frame_idx), 32'd0);
        pulse(10'd100, 10'd50, 1'b1);
        chk("anim 8 pulses frame", 32'(frame_idx), 32'd1);
        chk("anim frame1 addr", 32'(rom_address), 32'd1024);
        repeat (16) pulse(10'd100, 10'd50, 1'b1);
        chk("anim 24 pulses frame", 32'(frame_idx), 32'd3);
        chk("anim frame3 addr", 32'(rom_address), 32'd3072);
        repeat (8) pulse(10'd100, 10'd50, 1'b1);
        chk("anim 32 pulses wrap", 32'(frame_idx), 32'd0);

        // freeze holds the tick count rather than clearing it
        repeat (3) pulse(10'd100, 10'd50, 1'b1);
        repeat (5) pulse(10'd100, 10'd50, 1'b0);
        chk("anim frozen frame", 32'(frame_idx), 32'd0);
        repeat (4) pulse(10'd100, 10'd50, 1'b1);
        chk("anim resume 4 frame", 32'(frame_idx), 32'd0);
        pulse(10'd100, 10'd50, 1'b1);
        chk("anim resume 5 frame", 32'(frame_idx), 32'd1);

        // clipping at the right edge, frame 1
        pulse(10'd620, 10'd50, 1'b0);
        apply_check("clip x620", 10'd620, 10'd50, 1'b1, 4'h3, 3'd5, 12'd1024, 12'hDBA);
        apply_check("clip x639", 10'd639, 10'd50, 1'b1, 4'h3, 3'd5, 12'd1033, 12'hDBA);
        apply_check("clip x0", 10'd0, 10'd50, 1'b1, 4'h3, 3'd5, 12'd0, 12'h333);

        // mid-frame position change must not take effect until frame_start
        spr_x = 10'd0;
        apply_check("midframe x0", 10'd0, 10'd50, 1'b1, 4'h3, 3'd5, 12'd0, 12'h333);
        apply_check("midframe x620", 10'd620, 10'd50, 1'b1, 4'h3, 3'd5, 12'd1024, 12'hDBA);
        pulse(10'd0, 10'd50, 1'b0);
        apply_check("relatched x0", 10'd0, 10'd50, 1'b1, 4'h3, 3'd5, 12'd1024, 12'hDBA);

`ifdef SPRITE_HFLIP_EN
        hflip = 1'b1;
        pulse(10'd100, 10'd50, 1'b0);
        hflip = 1'b0;
        apply_check("hflip left", 10'd100, 10'd50, 1'b1, 4'h3, 3'd5, 12'd1055, 12'hDBA);
        apply_check("hflip right", 10'd163, 10'd50, 1'b1, 4'h3, 3'd5, 12'd1024, 12'hDBA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
Parametrised successor to the single-image full-screen ROM drawer. Draws one animated, scaled sprite at a movable screen position over a caller-supplied background colour, with a transparent palette index.
- Sprite frames are stored back to back in one external sprite ROM.
- Sits between the VGA controller's DrawX/DrawY/blank and the top-level RGB outputs.
- Drives the ROM address and palette index; composites the palette colour against the background.

Parameters:
SPR_W, 32, sprite width in texels (power of 2)
SPR_H, 32, sprite height in texels (power of 2)
SCALE_SHIFT, 1, each texel drawn as 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
NUM_FRAMES, 4, animation frames stored consecutively in ROM
FRAME_TICKS, 8, frame_start pulses per animation step (>=1)
IDX_W, 3, palette index width
ROM_LAT, 1, sprite ROM read latency in vga_clk cycles (>=1)
TRANSP_IDX, 0, palette index treated as transparent
ADDR_W, $clog2(NUM_FRAMES*SPR_W*SPR_H), ROM address width (derived)

Ports:
vga_clk  in  1  pixel clock; the block's only clock
reset  in  1  synchronous, active-high reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video
frame_start  in  1  one-cycle pulse at start of vertical blanking
spr_x  in  10  sprite left edge, screen pixels
spr_y  in  10  sprite top edge, screen pixels
anim_en  in  1  1 = animation advances
bg_red, bg_green, bg_blue  in  4 each  background colour, aligned with DrawX/DrawY
rom_address  out  ADDR_W  to sprite ROM
rom_q  in  IDX_W  ROM data, valid ROM_LAT cycles after the address
pal_index  out  IDX_W  to palette LUT (combinational)
pal_red, pal_green, pal_blue  in  4 each  palette LUT outputs
red, green, blue  out  4 each  registered pixel colour
frame_idx  out  $clog2(NUM_FRAMES)  current animation frame (debug and game logic)

Behaviour:
- Reset, synchronous, active-high:
  - tick counter = 0, frame_idx = 0, latched position = (0,0)
  - all delay-line stages cleared (hit = 0, blank = 0)
  - red/green/blue = 0
  - frame_start is ignored in the reset cycle.
- Position latch: spr_x/spr_y are captured only on the cycle frame_start = 1, so there is no mid-frame tearing. Mid-frame changes to spr_x/spr_y have no effect until the next frame_start.
- Animation:
  - On frame_start with anim_en = 1, the tick counter increments.
  - When the counter equals FRAME_TICKS-1, it wraps to 0 and frame_idx advances. NUM_FRAMES-1 wraps to 0.
  - anim_en = 0 freezes both the counter and frame_idx; values are held, not cleared.
  - FRAME_TICKS = 1 advances frame_idx on every frame_start.
- Hit test, combinational, 11-bit unsigned arithmetic:
  - dx = DrawX - lx, dy = DrawY - ly
  - hit = (DrawX >= lx) && (dx < SPR_W<<SCALE_SHIFT) && (DrawY >= ly) && (dy < SPR_H<<SCALE_SHIFT)
  - The sum lx + size may exceed 639, or 479 vertically; the sprite then clips at the screen edge with no wrap to column 0.
- Address, combinational:
  - col = dx >> SCALE_SHIFT, row = dy >> SCALE_SHIFT
  - rom_address = frame_idx*SPR_W*SPR_H + row*SPR_W + col
  - rom_address is forced to 0 when hit = 0.
  - The frame_idx used is the value registered at the time of the address, so frame changes only occur during vblank.
- Alignment: hit, blank and bg_* pass through a ROM_LAT-deep shift register so they arrive with rom_q.
- Composite, registered:
  - pal_index = rom_q
  - Next RGB is 0 if delayed blank = 0.
  - Otherwise it is the palette colour if delayed hit = 1 and rom_q != TRANSP_IDX.
  - Otherwise it is the delayed bg colour.
- Latency: DrawX/DrawY/blank/bg_* to red/green/blue is ROM_LAT+1 cycles. It is fixed and does not depend on data.
- A frame_start that arrives while the pipeline is in flight does not disturb pixels already in flight.

Optional Feature:
Macro SPRITE_HFLIP_EN.
- Defined:
  - Adds input port hflip (1 bit), latched on frame_start together with the position.
  - When the latched hflip = 1, col = SPR_W-1-(dx>>SCALE_SHIFT), so the sprite faces left.
  - Reset value of latched hflip = 0.
- Undefined: port absent, col never mirrored, no extra logic.

Test Plan:
- Reset: hold reset 3 cycles with blank = 1 and bg = 4'hF on all channels -> RGB = 0, frame_idx = 0, rom_address = 0. The first non-zero RGB appears ROM_LAT+1 cycles after reset deasserts.
- Position latch and latency: spr = (100,50) latched on frame_start. DrawX = 100, DrawY = 50 -> rom_address = 0, RGB = palette(rom_q) 2 cycles later (ROM_LAT = 1). DrawX = 163 -> col 31. DrawX = 164 -> background.
- Transparency: rom_q = TRANSP_IDX (0) inside the sprite, bg = 4'h3 on all channels -> RGB = 3,3,3. rom_q = 5 -> RGB = palette[5]. blank = 0 -> RGB = 0 regardless.
- Animation:
  - 8 frame_start pulses with anim_en = 1 -> frame_idx 0 to 1; address at sprite origin becomes 1024.
  - 32 pulses -> frame_idx wraps back to 0.
  - anim_en = 0 for 5 pulses -> frame_idx unchanged.
- Clipping and mid-frame update: spr_x = 620 -> pixels 620..639 drawn, no hit at DrawX = 0. Changing spr_x mid-frame -> no effect until the next frame_start.
- With SPRITE_HFLIP_EN: hflip = 1 latched, DrawX = spr_x -> col 31 (rom_address = 31). DrawX = spr_x+63 -> col 0.
